// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store on the data-RAM bus, stalls upstream
// until it completes or times out, and registers the writeback bundle for WB.
module mem_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result_in,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_sign_ext_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_write_data,
    input  logic        reg_write_en_in,
    input  logic [4:0]  reg_write_addr_in,
    input  logic [31:0] current_pc_addr_in,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data,
    input  logic        ram_ready,
    output logic        stall_request,
    output logic        mem_bus_error,
    output logic [31:0] result_out,
    output logic        reg_write_en_out,
    output logic [4:0]  reg_write_addr_out,
    output logic [31:0] current_pc_addr_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic        mem_op;
    logic [3:0]  sel_norm;
    logic [31:0] st_data;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic [3:0]  req_we, req_sel;
    logic        req_sign, req_load, req_rwe;
    logic [4:0]  req_rd;
    logic [15:0] wait_cnt;
    logic        timeout;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign mem_op = mem_read_flag | mem_write_flag;

    // Unlisted byte-select patterns collapse to a full word access.
    always_comb begin
        sel_norm = 4'b1111;
        st_data  = mem_write_data;
        case (mem_sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                sel_norm = mem_sel;
                st_data  = {4{mem_write_data[7:0]}};
            end
            4'b0011, 4'b1100: begin
                sel_norm = mem_sel;
                st_data  = {2{mem_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ram_read_data[7:0];
        ld_half = ram_read_data[15:0];
        ld_ext  = ram_read_data;
        case (req_sel)
            4'b0010: ld_byte = ram_read_data[15:8];
            4'b0100: ld_byte = ram_read_data[23:16];
            4'b1000: ld_byte = ram_read_data[31:24];
            4'b1100: ld_half = ram_read_data[31:16];
            default: ;
        endcase
        case (req_sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ld_ext = {{24{req_sign & ld_byte[7]}}, ld_byte};
            4'b0011, 4'b1100:                   ld_ext = {{16{req_sign & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    // A ready arriving on the last allowed cycle wins over the timeout.
    assign timeout = (state == BUSY) && !ram_ready && (wait_cnt == 16'(MAX_WAIT - 1));

    always_comb begin
        state_nxt     = state;
        stall_request = 1'b0;
        case (state)
            IDLE: if (mem_op) begin
                stall_request = 1'b1;
                state_nxt     = BUSY;
            end
            BUSY: begin
                stall_request = 1'b1;
                if (ram_ready || timeout) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_en         = (state == BUSY);
    assign ram_addr       = req_addr;
    assign ram_write_data = req_wdata;
    assign ram_write_en   = ram_en ? req_we : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state               <= IDLE;
            wait_cnt            <= '0;
            req_addr            <= '0;
            req_wdata           <= '0;
            req_pc              <= '0;
            req_we              <= '0;
            req_sel             <= '0;
            req_sign            <= 1'b0;
            req_load            <= 1'b0;
            req_rwe             <= 1'b0;
            req_rd              <= '0;
            mem_bus_error       <= 1'b0;
            result_out          <= '0;
            reg_write_en_out    <= 1'b0;
            reg_write_addr_out  <= '0;
            current_pc_addr_out <= '0;
        end else begin
            state         <= state_nxt;
            mem_bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        req_addr         <= {result_in[31:2], 2'b00};
                        req_we           <= mem_write_flag ? sel_norm : 4'b0000;
                        req_wdata        <= st_data;
                        req_sign         <= mem_sign_ext_flag;
                        req_sel          <= sel_norm;
                        req_load         <= ~mem_write_flag;
                        req_rwe          <= reg_write_en_in;
                        req_rd           <= reg_write_addr_in;
                        req_pc           <= current_pc_addr_in;
                        wait_cnt         <= '0;
                        reg_write_en_out <= 1'b0;
                    end else begin
                        result_out          <= result_in;
                        reg_write_en_out    <= reg_write_en_in;
                        reg_write_addr_out  <= reg_write_addr_in;
                        current_pc_addr_out <= current_pc_addr_in;
                    end
                end
                BUSY: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (ram_ready) begin
                        current_pc_addr_out <= req_pc;
                        if (req_load) begin
                            result_out         <= ld_ext;
                            reg_write_en_out   <= req_rwe;
                            reg_write_addr_out <= req_rd;
                        end else begin
                            reg_write_en_out <= 1'b0;
                        end
                    end else if (timeout) begin
                        mem_bus_error    <= 1'b1;
                        reg_write_en_out <= 1'b0;
                    end
                end
                DONE:    reg_write_en_out <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan scenarios plus randomized
// ALU/load/store traffic checked against a byte-lane reference model.
module tb_mem_stage;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result_in;
    logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] current_pc_addr_in;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr, ram_write_data, ram_read_data;
    logic        ram_ready;
    logic        stall_request, mem_bus_error;
    logic [31:0] result_out;
    logic        reg_write_en_out;
    logic [4:0]  reg_write_addr_out;
    logic [31:0] current_pc_addr_out;

    int vectors = 0;
    int miscompares = 0;

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .result_in(result_in),
        .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
        .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
        .mem_write_data(mem_write_data), .reg_write_en_in(reg_write_en_in),
        .reg_write_addr_in(reg_write_addr_in), .current_pc_addr_in(current_pc_addr_in),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .ram_ready(ram_ready), .stall_request(stall_request),
        .mem_bus_error(mem_bus_error), .result_out(result_out),
        .reg_write_en_out(reg_write_en_out), .reg_write_addr_out(reg_write_addr_out),
        .current_pc_addr_out(current_pc_addr_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] norm_sel(input logic [3:0] s);
        if (s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}) return s;
        return 4'b1111;
    endfunction

    // Width = number of enabled lanes, position = lowest enabled lane.
    function automatic logic [31:0] ref_load(input logic [3:0] sel, input logic sgn, input logic [31:0] d);
        logic [3:0]  s;
        logic [31:0] v, mask;
        int lo, nb;
        s  = norm_sel(sel);
        nb = $countones(s);
        lo = 0;
        for (int i = 3; i >= 0; i--) if (s[i]) lo = i;
        if (nb == 4) return d;
        v    = d >> (8 * lo);
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v    = v & mask;
        if (sgn && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] r;
        int nb;
        nb = $countones(norm_sel(sel));
        for (int lane = 0; lane < 4; lane++) r[8*lane +: 8] = d[8*(lane % nb) +: 8];
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_inputs(input logic rd, input logic wr, input logic sgn, input logic [3:0] sel,
                              input logic [31:0] res, input logic [31:0] wd, input logic rwe,
                              input logic [4:0] ra, input logic [31:0] pc);
        mem_read_flag      = rd;
        mem_write_flag     = wr;
        mem_sign_ext_flag  = sgn;
        mem_sel            = sel;
        result_in          = res;
        mem_write_data     = wd;
        reg_write_en_in    = rwe;
        reg_write_addr_in  = ra;
        current_pc_addr_in = pc;
    endtask

    task automatic set_nop();
        set_inputs(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // One non-memory instruction, then a nop whose window shows the retired values.
    task automatic run_alu(input string tag, input logic [31:0] res, input logic rwe,
                           input logic [4:0] ra, input logic [31:0] pc, input logic noise);
        @(posedge clk); #1;
        set_inputs(1'b0, 1'b0, $urandom_range(0, 1), 4'($urandom), res, $urandom, rwe, ra, pc);
        ram_ready = noise;
        ram_read_data = $urandom;
        #1;
        vectors++;
        if (stall_request !== 1'b0 || ram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL %s alu_idle: stall=%0b ram_en=%0b want 0 0", tag, stall_request, ram_en);
        end
        @(posedge clk); #1;
        set_nop();
        ram_ready = 1'b0;
        #1;
        vectors++;
        if ({result_out, reg_write_en_out, reg_write_addr_out, current_pc_addr_out} !== {res, rwe, ra, pc}) begin
            miscompares++;
            $display("FAIL %s alu_wb: got res=%h we=%0b ra=%0d pc=%h want res=%h we=%0b ra=%0d pc=%h",
                     tag, result_out, reg_write_en_out, reg_write_addr_out, current_pc_addr_out, res, rwe, ra, pc);
        end
    endtask

    // One memory op; k = BUSY cycle on which ram_ready rises (1..MW), 0 = never (timeout).
    task automatic run_mem(input string tag, input logic rd, input logic wr, input logic sgn,
                           input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wd,
                           input logic rwe, input logic [4:0] ra, input logic [31:0] pc,
                           input int k, input logic [31:0] rdata,
                           input logic [31:0] exp_res, input logic [31:0] exp_wd);
        logic       is_load;
        logic [3:0] exp_we;
        int         n_busy;
        is_load = rd & ~wr;
        exp_we  = is_load ? 4'b0000 : norm_sel(sel);
        n_busy  = (k == 0) ? MW : k;

        @(posedge clk); #1;
        set_inputs(rd, wr, sgn, sel, addr, wd, rwe, ra, pc);
        ram_ready = 1'b0;
        #1;
        vectors++;
        if (stall_request !== 1'b1 || ram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL %s issue: stall=%0b ram_en=%0b want 1 0", tag, stall_request, ram_en);
        end

        for (int i = 1; i <= n_busy; i++) begin
            @(posedge clk); #1;
            ram_ready     = (i == k);
            ram_read_data = (i == k) ? rdata : $urandom;
            #1;
            vectors++;
            if ({ram_en, stall_request, ram_addr, ram_write_en} !== {1'b1, 1'b1, addr[31:2], 2'b00, exp_we}) begin
                miscompares++;
                $display("FAIL %s busy%0d: en=%0b stall=%0b addr=%h we=%b want 1 1 %h %b",
                         tag, i, ram_en, stall_request, ram_addr, ram_write_en, {addr[31:2], 2'b00}, exp_we);
            end
            if (!is_load) begin
                vectors++;
                if (ram_write_data !== exp_wd) begin
                    miscompares++;
                    $display("FAIL %s wdata: got %h want %h", tag, ram_write_data, exp_wd);
                end
            end
        end

        @(posedge clk); #1;
        ram_ready     = 1'($urandom_range(0, 1));
        ram_read_data = $urandom;
        #1;
        vectors++;
        if ({stall_request, ram_en, mem_bus_error} !== {1'b0, 1'b0, (k == 0)}) begin
            miscompares++;
            $display("FAIL %s done_ctl: stall=%0b en=%0b err=%0b want 0 0 %0b",
                     tag, stall_request, ram_en, mem_bus_error, (k == 0));
        end
        vectors++;
        if (reg_write_en_out !== (k != 0 && is_load && rwe)) begin
            miscompares++;
            $display("FAIL %s done_we: got %0b want %0b", tag, reg_write_en_out, (k != 0 && is_load && rwe));
        end
        if (k != 0) begin
            vectors++;
            if (current_pc_addr_out !== pc) begin
                miscompares++;
                $display("FAIL %s done_pc: got %h want %h", tag, current_pc_addr_out, pc);
            end
        end
        if (k != 0 && is_load) begin
            vectors++;
            if (result_out !== exp_res || reg_write_addr_out !== ra) begin
                miscompares++;
                $display("FAIL %s load_data: got %h ra=%0d want %h ra=%0d",
                         tag, result_out, reg_write_addr_out, exp_res, ra);
            end
        end

        @(posedge clk); #1;
        set_nop();
        ram_ready = 1'b0;
        #1;
        vectors++;
        if ({reg_write_en_out, mem_bus_error, stall_request, ram_en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s bubble: we=%0b err=%0b stall=%0b en=%0b want 0000",
                     tag, reg_write_en_out, mem_bus_error, stall_request, ram_en);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        set_nop();
        ram_ready = 1'b1;
        ram_read_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({ram_en, ram_write_en, ram_addr, ram_write_data, stall_request, mem_bus_error,
             result_out, reg_write_en_out, reg_write_addr_out, current_pc_addr_out} !== '0) begin
            miscompares++;
            $display("FAIL reset: outputs not zero (en=%0b we=%b addr=%h res=%h wen=%0b stall=%0b)",
                     ram_en, ram_write_en, ram_addr, result_out, reg_write_en_out, stall_request);
        end
        rst = 1'b1;
        ram_ready = 1'b0;
    endtask

    task automatic test_alu();
        run_alu("alu_42", 32'h0000_0042, 1'b1, 5'd5, 32'h0000_0100, 1'b0);
        run_alu("alu_ready_noise", 32'hCAFE_0001, 1'b1, 5'd31, 32'h0000_0104, 1'b1);
    endtask

    task automatic test_loads();
        run_mem("ld_sbyte", 1'b1, 1'b0, 1'b1, 4'b1000, 32'h1000_0003, 32'h0, 1'b1, 5'd7, 32'h0000_0200,
                3, 32'h80FF_FFFF, 32'hFFFF_FF80, 32'h0);
        run_mem("ld_zhalf", 1'b1, 1'b0, 1'b0, 4'b1100, 32'h2000_0002, 32'h0, 1'b1, 5'd9, 32'h0000_0204,
                1, 32'h8001_1234, 32'h0000_8001, 32'h0);
        run_mem("ld_bad_sel_word", 1'b1, 1'b0, 1'b1, 4'b0101, 32'h2000_0010, 32'h0, 1'b1, 5'd3, 32'h0000_0208,
                2, 32'h8765_4321, 32'h8765_4321, 32'h0);
    endtask

    task automatic test_stores();
        run_mem("st_half", 1'b0, 1'b1, 1'b0, 4'b0011, 32'h3000_0000, 32'hDEAD_BEEF, 1'b1, 5'd4, 32'h0000_0300,
                2, 32'h0, 32'h0, 32'hBEEF_BEEF);
        run_mem("st_rd_wr_both", 1'b1, 1'b1, 1'b0, 4'b0100, 32'h3000_0006, 32'h1234_56A5, 1'b1, 5'd4, 32'h0000_0304,
                1, 32'hFFFF_FFFF, 32'h0, 32'hA5A5_A5A5);
    endtask

    task automatic test_timeout();
        run_mem("timeout", 1'b1, 1'b0, 1'b0, 4'b1111, 32'h4000_0000, 32'h0, 1'b1, 5'd6, 32'h0000_0400,
                0, 32'h0, 32'h0, 32'h0);
        run_alu("after_timeout", 32'h0000_1111, 1'b1, 5'd8, 32'h0000_0404, 1'b0);
        run_mem("ready_at_limit", 1'b1, 1'b0, 1'b1, 4'b0001, 32'h4000_0004, 32'h0, 1'b1, 5'd2, 32'h0000_0408,
                MW, 32'h0000_007F, 32'h0000_007F, 32'h0);
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1;
        set_inputs(1'b1, 1'b0, 1'b0, 4'b1111, 32'h5000_0000, 32'h0, 1'b1, 5'd12, 32'h0000_0500);
        ram_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (ram_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid busy2: ram_en=%0b want 1", ram_en);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        set_nop();
        ram_ready = 1'b1;
        ram_read_data = 32'h1234_5678;
        #1;
        vectors++;
        if ({ram_en, ram_write_en, ram_addr, ram_write_data, stall_request, mem_bus_error,
             result_out, reg_write_en_out, reg_write_addr_out, current_pc_addr_out} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid zero: en=%0b addr=%h res=%h wen=%0b stall=%0b want all 0",
                     ram_en, ram_addr, result_out, reg_write_en_out, stall_request);
        end
        @(posedge clk); #1;
        ram_ready = 1'b0;
        #1;
        vectors++;
        if ({ram_en, reg_write_en_out, stall_request, result_out} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid late_ready: en=%0b wen=%0b stall=%0b res=%h want 0",
                     ram_en, reg_write_en_out, stall_request, result_out);
        end
    endtask

    task automatic test_random();
        logic [3:0]  sels [7];
        logic [3:0]  sel;
        logic [31:0] addr, wd, rdata, pc;
        logic        sgn, both, rwe;
        logic [4:0]  ra;
        int          kind, k;
        sels = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 2);
            addr  = $urandom;
            wd    = $urandom;
            rdata = $urandom;
            pc    = $urandom;
            sgn   = 1'($urandom_range(0, 1));
            rwe   = 1'($urandom_range(0, 1));
            ra    = 5'($urandom);
            both  = ($urandom_range(0, 7) == 0);
            sel   = ($urandom_range(0, 7) == 7) ? 4'($urandom) : sels[$urandom_range(0, 6)];
            k     = $urandom_range(0, MW);
            case (kind)
                0: run_alu("rnd_alu", addr, rwe, ra, pc, 1'($urandom_range(0, 1)));
                1: run_mem("rnd_load", 1'b1, 1'b0, sgn, sel, addr, wd, rwe, ra, pc, k, rdata,
                           ref_load(sel, sgn, rdata), 32'h0);
                default: run_mem("rnd_store", both, 1'b1, sgn, sel, addr, wd, rwe, ra, pc, k, rdata,
                                 32'h0, ref_store(sel, wd));
            endcase
        end
    endtask

    initial begin
        set_nop();
        rst = 1'b0;
        ram_ready = 1'b0;
        ram_read_data = 32'h0;
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
